// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: one full adder is reused LSB-first over WIDTH
// cycles, with a start/ready/done handshake and C/V/Z flags on completion.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_addsub_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             start_in,
   input  logic             sub_in,
   input  logic [WIDTH-1:0] A_in,
   input  logic [WIDTH-1:0] B_in,
   output logic             ready_out,
   output logic             done_out,
   output logic [WIDTH-1:0] result_out,
   output logic             C_out,
   output logic             V_out,
   output logic             Z_out
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] PRE_MSB  = CW'(WIDTH - 2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           next_state_s;
   logic             accept_s;
   logic             last_bit_s;
   logic [WIDTH-1:0] sa_r;
   logic [WIDTH-1:0] sb_r;
   logic [WIDTH-1:0] res_sh_r;
   logic [CW-1:0]    cnt_r;
   logic             carry_r;
   logic             cmsb_r;
   logic             fa_s_s;
   logic             fa_co_s;
   logic [WIDTH-1:0] final_res_s;

   full_adder u_fa (
      .a  (sa_r[0]),
      .b  (sb_r[0]),
      .ci (carry_r),
      .s  (fa_s_s),
      .co (fa_co_s)
   );

   // The bit produced this cycle lands at the MSB end; on the last cycle this is the full result.
   assign final_res_s = {fa_s_s, res_sh_r[WIDTH-1:1]};

   // Next-state decode, accept strobe and last-bit strobe.
   always_comb begin
      next_state_s = state_r;
      accept_s     = 1'b0;
      last_bit_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (start_in && ready_out) begin
               next_state_s = RUN;
               accept_s     = 1'b1;
            end else begin
               next_state_s = IDLE;
            end
         end
         RUN: begin
            if (cnt_r == LAST_BIT) begin
               next_state_s = DONE;
               last_bit_s   = 1'b1;
            end else begin
               next_state_s = RUN;
            end
         end
         DONE:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // State register with handshake outputs registered from the next state.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_r   <= IDLE;
         ready_out <= 1'b1;
         done_out  <= 1'b0;
      end else begin
         state_r   <= next_state_s;
         ready_out <= (next_state_s == IDLE);
         done_out  <= (next_state_s == DONE);
      end
   end

   // Operand shifters, carry chain, bit counter and result/flag capture.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sa_r       <= {WIDTH{1'b0}};
         sb_r       <= {WIDTH{1'b0}};
         res_sh_r   <= {WIDTH{1'b0}};
         cnt_r      <= {CW{1'b0}};
         carry_r    <= 1'b0;
         cmsb_r     <= 1'b0;
         result_out <= {WIDTH{1'b0}};
         C_out      <= 1'b0;
         V_out      <= 1'b0;
         Z_out      <= 1'b0;
      end else if (accept_s) begin
         // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
         sa_r    <= A_in;
         sb_r    <= sub_in ? ~B_in : B_in;
         carry_r <= sub_in;
         cnt_r   <= {CW{1'b0}};
         cmsb_r  <= 1'b0;
      end else if (state_r == RUN) begin
         sa_r     <= {1'b0, sa_r[WIDTH-1:1]};
         sb_r     <= {1'b0, sb_r[WIDTH-1:1]};
         res_sh_r <= final_res_s;
         carry_r  <= fa_co_s;
         if (cnt_r == PRE_MSB) begin
            cmsb_r <= fa_co_s;
         end
         if (last_bit_s) begin
            result_out <= final_res_s;
            C_out      <= fa_co_s;
            V_out      <= cmsb_r ^ fa_co_s;
            Z_out      <= (final_res_s == {WIDTH{1'b0}});
         end else begin
            cnt_r <= cnt_r + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl at WIDTH=8, plus random sweeps at WIDTH=32 and WIDTH=2.

module tb_serial_addsub_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       st8, sb8, rdy8, dn8, c8, v8, z8;
   logic [7:0] a8, b8, res8;
   logic        st32, sb32, rdy32, dn32, c32, v32, z32;
   logic [31:0] a32, b32, res32;
   logic       st2, sb2, rdy2, dn2, c2, v2, z2;
   logic [1:0] a2, b2, res2;

   serial_addsub_ctrl #(.WIDTH(8)) dut8 (
      .clk_in(clk), .rst_in(rst), .start_in(st8), .sub_in(sb8), .A_in(a8), .B_in(b8),
      .ready_out(rdy8), .done_out(dn8), .result_out(res8), .C_out(c8), .V_out(v8), .Z_out(z8));
   serial_addsub_ctrl #(.WIDTH(32)) dut32 (
      .clk_in(clk), .rst_in(rst), .start_in(st32), .sub_in(sb32), .A_in(a32), .B_in(b32),
      .ready_out(rdy32), .done_out(dn32), .result_out(res32), .C_out(c32), .V_out(v32), .Z_out(z32));
   serial_addsub_ctrl #(.WIDTH(2)) dut2 (
      .clk_in(clk), .rst_in(rst), .start_in(st2), .sub_in(sb2), .A_in(a2), .B_in(b2),
      .ready_out(rdy2), .done_out(dn2), .result_out(res2), .C_out(c2), .V_out(v2), .Z_out(z2));

   int          w_sel = 8;
   logic [63:0] res_m;
   logic        rdy_m, dn_m, c_m, v_m, z_m;

   always_comb begin
      res_m = 64'(res8); rdy_m = rdy8; dn_m = dn8; c_m = c8; v_m = v8; z_m = z8;
      case (w_sel)
         32: begin res_m = 64'(res32); rdy_m = rdy32; dn_m = dn32; c_m = c32; v_m = v32; z_m = z32; end
         2:  begin res_m = 64'(res2);  rdy_m = rdy2;  dn_m = dn2;  c_m = c2;  v_m = v2;  z_m = z2;  end
         default: ;
      endcase
   end

   int n_asrt = 0;
   int n_fail = 0;
   int cyc = 0;
   int last_done = -1;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: {C, V, Z, result}; V from operand/result signs, C as carry-out or no-borrow.
   function automatic logic [66:0] model(input int w, input logic sub,
                                         input logic [63:0] a_i, input logic [63:0] b_i);
      logic [63:0] mask, a, b, res;
      logic [64:0] full;
      logic        c, v, sa, sbb, sr;
      mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      a = a_i & mask;
      b = b_i & mask;
      full = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      res = full[63:0] & mask;
      c = sub ? (a >= b) : full[w];
      sa = a[w-1]; sbb = b[w-1]; sr = res[w-1];
      v = sub ? ((sa != sbb) && (sr != sa)) : ((sa == sbb) && (sr != sa));
      return {c, v, (res == 64'd0), res};
   endfunction

   task automatic drive(input int w, input logic st, input logic sub,
                        input logic [63:0] a, input logic [63:0] b);
      case (w)
         32: begin st32 = st; sb32 = sub; a32 = a[31:0]; b32 = b[31:0]; end
         2:  begin st2 = st;  sb2 = sub;  a2 = a[1:0];   b2 = b[1:0];   end
         default: begin st8 = st; sb8 = sub; a8 = a[7:0]; b8 = b[7:0]; end
      endcase
   endtask

   task automatic run_op(input int w, input logic sub, input logic [63:0] a, input logic [63:0] b,
                         input bit hold_start, input bit scramble);
      logic [66:0] exp;
      logic [63:0] prev;
      int lat, low;
      w_sel = w;
      exp = model(w, sub, a, b);
      @(negedge clk);
      prev = res_m;
      drive(w, 1'b1, sub, a, b);
      @(posedge clk); #1;
      lat = 0; low = 0;
      check("ready_fall", 64'(rdy_m), 64'd0);
      if (!rdy_m) low++;
      if (!hold_start) drive(w, 1'b0, sub, a, b);
      while (!dn_m && lat < w + 4) begin
         check("hold_run", res_m, prev);
         if (scramble) drive(w, hold_start, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
         @(posedge clk); #1;
         lat++;
         if (!rdy_m) low++;
      end
      check("latency", 64'(lat), 64'(w));
      check("done_hi", 64'(dn_m), 64'd1);
      check("result", res_m, exp[63:0]);
      check("C", 64'(c_m), 64'(exp[66]));
      check("V", 64'(v_m), 64'(exp[65]));
      check("Z", 64'(z_m), 64'(exp[64]));
      if (hold_start && last_done >= 0) check("period", 64'(cyc - last_done), 64'(w + 2));
      last_done = cyc;
      @(posedge clk); #1;
      check("done_lo", 64'(dn_m), 64'd0);
      check("ready_back", 64'(rdy_m), 64'd1);
      check("ready_low_cnt", 64'(low), 64'(w + 1));
      check("hold_idle", res_m, exp[63:0]);
   endtask

   task automatic check_hand(input string tag, input logic [63:0] r, input logic c, input logic v, input logic z);
      check({tag, "_res"}, res_m, r);
      check({tag, "_C"}, 64'(c_m), 64'(c));
      check({tag, "_V"}, 64'(v_m), 64'(v));
      check({tag, "_Z"}, 64'(z_m), 64'(z));
   endtask

   initial begin
      int seen;
      rst = 1'b1;
      drive(8, 1'b0, 1'b0, 64'd0, 64'd0);
      drive(32, 1'b0, 1'b0, 64'd0, 64'd0);
      drive(2, 1'b0, 1'b0, 64'd0, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      w_sel = 8;
      #1;
      check("rst_ready", 64'(rdy_m), 64'd1);
      check("rst_done", 64'(dn_m), 64'd0);
      check_hand("rst", 64'h0, 1'b0, 1'b0, 1'b0);

      run_op(8, 1'b0, 64'h7F, 64'h01, 1'b0, 1'b0);
      check_hand("add_7f_01", 64'h80, 1'b0, 1'b1, 1'b0);
      run_op(8, 1'b0, 64'hFF, 64'h01, 1'b0, 1'b0);
      check_hand("add_ff_01", 64'h00, 1'b1, 1'b0, 1'b1);
      run_op(8, 1'b1, 64'h05, 64'h07, 1'b0, 1'b0);
      check_hand("sub_05_07", 64'hFE, 1'b0, 1'b0, 1'b0);
      run_op(8, 1'b1, 64'h80, 64'h01, 1'b0, 1'b0);
      check_hand("sub_80_01", 64'h7F, 1'b1, 1'b1, 1'b0);

      // Asynchronous reset in the middle of RUN cycle 3
      @(negedge clk);
      drive(8, 1'b1, 1'b0, 64'h55, 64'h22);
      @(posedge clk); #1;
      drive(8, 1'b0, 1'b0, 64'h55, 64'h22);
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_ready", 64'(rdy_m), 64'd1);
      check("midrst_done", 64'(dn_m), 64'd0);
      check_hand("midrst", 64'h0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (dn_m) seen++;
      end
      check("midrst_no_done", 64'(seen), 64'd0);
      run_op(8, 1'b0, 64'h12, 64'h34, 1'b0, 1'b0);
      check_hand("add_12_34", 64'h46, 1'b0, 1'b0, 1'b0);

      // start_in held high, operands scrambled during RUN
      last_done = -1;
      for (int i = 0; i < 20; i++)
         run_op(8, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b1);
      drive(8, 1'b0, 1'b0, 64'd0, 64'd0);

      last_done = -1;
      run_op(32, 1'b1, 64'h0, 64'h1, 1'b0, 1'b0);
      check_hand("w32_0_minus_1", 64'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 1000; i++)
         run_op(32, 1'($urandom_range(0, 1)), 64'($urandom), 64'($urandom), 1'b0, 1'b0);

      run_op(2, 1'b0, 64'h1, 64'h1, 1'b0, 1'b0);
      check_hand("w2_1_plus_1", 64'h2, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 1000; i++)
         run_op(2, 1'($urandom_range(0, 1)), 64'($urandom_range(0, 3)), 64'($urandom_range(0, 3)), 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
